uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised next-generation UART transmitter with an integrated transmit FIFO and 16550-style line control. Supports 5–8 data bits, none/odd/even/stick parity, and 1, 1.5 or 2 stop bits. Sends back-to-back frames with no idle gap and provides break generation. Sits between the RISC-V bus register block, which pushes bytes and drives the line-control fields, and the shared baud/oversample tick generator.

Parameters:
OVERSAMPLE, 16, tick_en pulses per bit period; must be even and at least 4.
FIFO_DEPTH, 16, transmit FIFO entries; power of two, at least 2.
CNT_W, $clog2(FIFO_DEPTH+1), width of fifo_count (derived; not overridden).

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
tick_en  input  1  oversample tick, one clk wide
wr_data  input  8  byte to enqueue; bits above the word length are ignored
wr_valid  input  1  write request
wr_ready  output  1  FIFO can accept; equals !fifo_full
fifo_clear  input  1  flush FIFO, one-cycle pulse
lcr_wls  input  2  word length: 0=5, 1=6, 2=7, 3=8 bits
lcr_stb  input  1  0=1 stop bit; 1=2 stop bits, or 1.5 stop bits when wls=0
lcr_pen  input  1  parity enable
lcr_eps  input  1  even parity select
lcr_sp  input  1  stick parity
lcr_brk  input  1  break control
tx  output  1  serial line
tx_busy  output  1  frame in progress
tx_done  output  1  one-cycle pulse at end of each frame
fifo_empty  output  1  FIFO empty
fifo_full  output  1  FIFO full
fifo_count  output  CNT_W  FIFO occupancy

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-low on rst_n.
- Reset values: tx=1, tx_busy=0, tx_done=0, fifo_empty=1, fifo_full=0, fifo_count=0, state=IDLE. Reset asserted mid-frame aborts the frame; tx returns to 1 on the next clk edge.
- FIFO push: occurs on wr_valid && wr_ready.
  - No write-through when full, even if a pop occurs in the same cycle.
  - fifo_count updates one cycle after the push or pop.
- fifo_clear:
  - Empties the FIFO on the next edge and does not abort the frame in flight.
  - When fifo_clear and a push coincide, the clear wins and the pushed word is dropped.
- Bit timing: tick counter tcnt runs 0..OVERSAMPLE-1. All state and tx changes happen only in cycles where tick_en=1. Each bit lasts exactly OVERSAMPLE ticks; a 1.5-stop frame lasts 1.5*OVERSAMPLE ticks in STOP.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. On a tick with FIFO non-empty: pop, latch the byte and all lcr_* fields into frame registers, tx<=0, tcnt<=0, tx_busy<=1, go to START. Parity is computed from the latched fields at the same time.
  - START: on the tick with tcnt=OVERSAMPLE-1, drive data bit 0 (LSB first), bit_idx<=0, go to DATA.
  - DATA: at the end of each bit, advance bit_idx. After bit (wls+5)-1, go to PARITY if pen is set, else STOP, driving the parity bit or 1 accordingly.
  - PARITY: parity bit value:
    - sp=0: XOR of the data bits, inverted when eps=0 (odd parity).
    - sp=1: the constant ~eps.
    - Lasts one bit period, then STOP with tx<=1.
  - STOP: lasts 1, 1.5 or 2 bit periods. On its final tick, pulse tx_done.
    - If the FIFO is non-empty in that cycle: pop and go directly to START with tx<=0. No idle gap; tx_busy stays 1.
    - Otherwise go to IDLE with tx_busy<=0.
- Line control changes mid-frame have no effect until the next frame.
- Break: while lcr_brk=1, the tx pin is forced to 0 combinationally-after-register (tx = tx_q & ~lcr_brk). The FSM keeps running and consuming the FIFO.
- tick_en while idle with an empty FIFO: no effect.

Decomposition:
- Shared package uart_pkg holds:
  - tx state enum;
  - WLS encodings;
  - helper function for the parity bit;
  - function returning stop-bit tick length given OVERSAMPLE, stb and wls.
- Natural sub-module: uart_sync_fifo (parameters WIDTH, DEPTH).
  - Synchronous active-low reset, push/pop/clear ports.
  - Outputs: count, empty, full.
  - Reusable by the future receiver.

Test Plan:
- 8N1, OVERSAMPLE=16, push 0xA5 → tx low for 16 ticks, then bits 1,0,1,0,0,1,0,1 at 16 ticks each, then high for 16 ticks; tx_done pulses once; tx_busy is high for exactly 160 ticks.
- 7E1 with 0x41 → 7 data bits 1,0,0,0,0,0,1; parity bit 0; 1 stop. Repeat with eps=0: parity bit 1. Repeat with sp=1, eps=1: parity bit forced 0.
- 5-bit word, stb=1, byte 0x1F → 5 data bits of 1 followed by a stop interval of 24 ticks; with wls=3, stb=1, the stop interval is 32 ticks.
- Push 17 bytes back-to-back while idle → wr_ready drops after 16 are accepted; fifo_full=1. Frames are emitted with start bits directly after stop bits (zero idle ticks); fifo_count decrements on each frame start.
- Assert lcr_brk mid-frame for 40 ticks → tx=0 throughout. The FIFO is still drained, and tx resumes normal levels on deassertion.
- Assert rst_n=0 during DATA, and separately pulse fifo_clear during DATA → reset: tx=1 and the FIFO is empty next cycle. Clear: the current frame completes and no further frames are sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter (and the future receiver):
// FSM state encodings, word-length codes, parity and stop-length helpers.
package uart_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   localparam logic [1:0] WLS_5 = 2'd0;
   localparam logic [1:0] WLS_6 = 2'd1;
   localparam logic [1:0] WLS_7 = 2'd2;
   localparam logic [1:0] WLS_8 = 2'd3;

   function automatic logic [7:0] wls_mask(input logic [1:0] wls);
      logic [7:0] m;
      case (wls)
         WLS_5:   m = 8'h1F;
         WLS_6:   m = 8'h3F;
         WLS_7:   m = 8'h7F;
         default: m = 8'hFF;
      endcase
      return m;
   endfunction

   // Stick parity overrides the data-derived value with the constant ~eps.
   function automatic logic parity_bit(input logic [7:0] data,
                                       input logic [1:0] wls,
                                       input logic       eps,
                                       input logic       sp);
      logic x;
      x = ^(data & wls_mask(wls));
      if (sp) return ~eps;
      return eps ? x : ~x;
   endfunction

   function automatic int stop_ticks(input int         oversample,
                                     input logic       stb,
                                     input logic [1:0] wls);
      if (!stb) return oversample;
      if (wls == WLS_5) return oversample + oversample / 2;
      return 2 * oversample;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read, push/pop/clear and
// occupancy flags. Clear dominates a simultaneous push or pop.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   input  logic             clear,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full
);

   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_reg;
   logic [ADDR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0]  count_reg;
   logic              push_ok;
   logic              pop_ok;

   assign full    = (count_reg == CNT_W'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
   assign push_ok = push && !full && !clear;
   assign pop_ok  = pop && !empty && !clear;
   assign rd_data = mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with transmit FIFO, 16550-style line control, back-to-back
// framing and break; all line activity is paced by the external oversample tick.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 16,
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick_en,
   input  logic [7:0]       wr_data,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic             fifo_clear,
   input  logic [1:0]       lcr_wls,
   input  logic             lcr_stb,
   input  logic             lcr_pen,
   input  logic             lcr_eps,
   input  logic             lcr_sp,
   input  logic             lcr_brk,
   output logic             tx,
   output logic             tx_busy,
   output logic             tx_done,
   output logic             fifo_empty,
   output logic             fifo_full,
   output logic [CNT_W-1:0] fifo_count
);

   // Wide enough for the longest interval, two stop bits.
   localparam int                TCNT_W   = $clog2(2 * OVERSAMPLE);
   localparam logic [TCNT_W-1:0] BIT_LAST = TCNT_W'(OVERSAMPLE - 1);

   logic [2:0]        state_reg;
   logic [TCNT_W-1:0] tcnt_reg;
   logic [2:0]        bit_idx_reg;
   logic [7:0]        data_reg;
   logic [1:0]        wls_reg;
   logic              stb_reg;
   logic              pen_reg;
   logic              par_reg;
   logic              tx_q_reg;
   logic              busy_reg;
   logic              done_reg;

   logic [7:0]        fifo_rd_data;
   logic              fifo_pop;
   logic              bit_end;
   logic              stop_end;
   logic [TCNT_W-1:0] stop_last;
   logic [2:0]        last_data_idx;

   uart_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (wr_valid),
      .wr_data (wr_data),
      .pop     (fifo_pop),
      .rd_data (fifo_rd_data),
      .clear   (fifo_clear),
      .count   (fifo_count),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   assign wr_ready      = !fifo_full;
   assign bit_end       = (tcnt_reg == BIT_LAST);
   assign last_data_idx = {1'b0, wls_reg} + 3'd4;
   assign stop_last     = TCNT_W'(stop_ticks(OVERSAMPLE, stb_reg, wls_reg) - 1);
   assign stop_end      = tick_en && (state_reg == ST_STOP) && (tcnt_reg == stop_last);

   // A new frame starts from IDLE or straight out of the last stop tick.
   assign fifo_pop = tick_en && !fifo_empty &&
                     ((state_reg == ST_IDLE) || stop_end);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg   <= ST_IDLE;
         tcnt_reg    <= '0;
         bit_idx_reg <= '0;
         data_reg    <= '0;
         wls_reg     <= WLS_5;
         stb_reg     <= 1'b0;
         pen_reg     <= 1'b0;
         par_reg     <= 1'b0;
         tx_q_reg    <= 1'b1;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         done_reg <= stop_end;
         if (fifo_pop) begin
            // Line control is frozen here for the whole frame.
            data_reg    <= fifo_rd_data;
            wls_reg     <= lcr_wls;
            stb_reg     <= lcr_stb;
            pen_reg     <= lcr_pen;
            par_reg     <= parity_bit(fifo_rd_data, lcr_wls, lcr_eps, lcr_sp);
            tx_q_reg    <= 1'b0;
            tcnt_reg    <= '0;
            bit_idx_reg <= '0;
            busy_reg    <= 1'b1;
            state_reg   <= ST_START;
         end else if (tick_en) begin
            case (state_reg)
               ST_IDLE: begin
                  tx_q_reg <= 1'b1;
               end
               ST_START: begin
                  if (bit_end) begin
                     tcnt_reg    <= '0;
                     bit_idx_reg <= '0;
                     tx_q_reg    <= data_reg[0];
                     state_reg   <= ST_DATA;
                  end else begin
                     tcnt_reg <= tcnt_reg + TCNT_W'(1);
                  end
               end
               ST_DATA: begin
                  if (bit_end) begin
                     tcnt_reg <= '0;
                     if (bit_idx_reg == last_data_idx) begin
                        if (pen_reg) begin
                           tx_q_reg  <= par_reg;
                           state_reg <= ST_PARITY;
                        end else begin
                           tx_q_reg  <= 1'b1;
                           state_reg <= ST_STOP;
                        end
                     end else begin
                        bit_idx_reg <= bit_idx_reg + 3'd1;
                        tx_q_reg    <= data_reg[bit_idx_reg + 3'd1];
                     end
                  end else begin
                     tcnt_reg <= tcnt_reg + TCNT_W'(1);
                  end
               end
               ST_PARITY: begin
                  if (bit_end) begin
                     tcnt_reg  <= '0;
                     tx_q_reg  <= 1'b1;
                     state_reg <= ST_STOP;
                  end else begin
                     tcnt_reg <= tcnt_reg + TCNT_W'(1);
                  end
               end
               ST_STOP: begin
                  if (tcnt_reg == stop_last) begin
                     tcnt_reg  <= '0;
                     busy_reg  <= 1'b0;
                     state_reg <= ST_IDLE;
                  end else begin
                     tcnt_reg <= tcnt_reg + TCNT_W'(1);
                  end
               end
               default: begin
                  tx_q_reg  <= 1'b1;
                  busy_reg  <= 1'b0;
                  state_reg <= ST_IDLE;
               end
            endcase
         end
      end
   end

   // Break overrides the pin only; the frame machinery keeps running.
   assign tx      = tx_q_reg & ~lcr_brk;
   assign tx_busy = busy_reg;
   assign tx_done = done_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: stimulus queues expected frames, a tick-rate line
// monitor decodes tx and compares every frame against the queue.
module tb_uart_tx_fifo;

   localparam int OS    = 16;
   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          tick_en = 1'b0;
   logic [7:0]    wr_data = 8'h00;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic          fifo_clear = 1'b0;
   logic [1:0]    lcr_wls = 2'd3;
   logic          lcr_stb = 1'b0;
   logic          lcr_pen = 1'b0;
   logic          lcr_eps = 1'b0;
   logic          lcr_sp = 1'b0;
   logic          lcr_brk = 1'b0;
   logic          tx;
   logic          tx_busy;
   logic          tx_done;
   logic          fifo_empty;
   logic          fifo_full;
   logic [CW-1:0] fifo_count;

   uart_tx_fifo #(.OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick_en    (tick_en),
      .wr_data    (wr_data),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .fifo_clear (fifo_clear),
      .lcr_wls    (lcr_wls),
      .lcr_stb    (lcr_stb),
      .lcr_pen    (lcr_pen),
      .lcr_eps    (lcr_eps),
      .lcr_sp     (lcr_sp),
      .lcr_brk    (lcr_brk),
      .tx         (tx),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done),
      .fifo_empty (fifo_empty),
      .fifo_full  (fifo_full),
      .fifo_count (fifo_count)
   );

   initial forever #5 clk = ~clk;

   // Tick on every other clock so that non-tick cycles are exercised too.
   logic tick_run = 1'b0;
   initial forever begin
      @(negedge clk);
      tick_en = tick_run & ~tick_en;
   end

   typedef struct {
      logic [10:0] lvl;
      int          nbits;
      int          stop_len;
      logic [7:0]  byte_v;
      logic        b2b;
   } frame_t;

   typedef struct packed {
      logic [7:0] b;
      logic [1:0] wls;
      logic       stb;
      logic       pen;
      logic       eps;
      logic       sp;
      logic [3:0] nd;
      logic       par;
      logic [5:0] stop;
   } vec_t;

   frame_t exp_q[$];
   int     total = 0;
   int     bad = 0;
   int     done_cnt = 0;
   int     busy_ticks = 0;
   logic   mon_en = 1'b1;

   // Monitor state
   frame_t m_cur;
   logic   m_active = 1'b0;
   logic   m_stray = 1'b0;
   logic   m_early = 1'b0;
   int     m_idx = 0;
   int     m_total = 0;
   int     m_bad = -1;
   logic   m_badv = 1'b0;
   logic   m_bade = 1'b0;
   int     m_frames = 0;
   logic   smp_tick;

   function automatic frame_t mk_frame(input logic [7:0] b, input int nd,
                                       input logic pen, input logic par,
                                       input int stop_len, input logic b2b);
      frame_t f;
      f.lvl = '0;
      for (int i = 0; i < nd; i++) f.lvl[i + 1] = b[i];
      f.nbits = nd + 1;
      if (pen) begin
         f.lvl[nd + 1] = par;
         f.nbits++;
      end
      f.stop_len = stop_len;
      f.byte_v   = b;
      f.b2b      = b2b;
      return f;
   endfunction

   task automatic mon_step(input logic tx_s, input logic done_s);
      logic exp_l;
      if (m_active) begin
         if (m_idx < m_total) begin
            exp_l = (m_idx < m_cur.nbits * OS) ? m_cur.lvl[m_idx / OS] : 1'b1;
            if (tx_s !== exp_l && m_bad < 0) begin
               m_bad  = m_idx;
               m_badv = tx_s;
               m_bade = exp_l;
            end
            if (done_s !== 1'b0) m_early = 1'b1;
            m_idx++;
         end else begin
            total++;
            if (m_bad >= 0 || m_early || done_s !== 1'b1 ||
                (m_cur.b2b && tx_s !== 1'b0)) begin
               bad++;
               $display("FAIL frame %0d byte=%02h: bad_tick=%0d got=%b want=%b done_at_end=%b (want 1) early_done=%b b2b_start=%b",
                        m_frames, m_cur.byte_v, m_bad, m_badv, m_bade, done_s, m_early,
                        m_cur.b2b ? ~tx_s : 1'b1);
            end else begin
               $display("frame %0d byte=%02h ok (%0d ticks)", m_frames, m_cur.byte_v, m_total);
            end
            m_frames++;
            m_active = 1'b0;
         end
      end
      if (!m_active && tx_s === 1'b0 && !m_stray) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            m_stray = 1'b1;
            $display("FAIL unexpected_start: got start bit, want idle line");
         end else begin
            m_cur    = exp_q.pop_front();
            m_active = 1'b1;
            m_idx    = 1;
            m_total  = m_cur.nbits * OS + m_cur.stop_len;
            m_bad    = -1;
            m_early  = 1'b0;
         end
      end
      if (tx_s === 1'b1) m_stray = 1'b0;
   endtask

   initial forever begin
      @(posedge clk);
      smp_tick = tick_en;
      #1;
      if (tx_done === 1'b1) done_cnt++;
      if (smp_tick) begin
         if (tx_busy === 1'b1) busy_ticks++;
         if (mon_en) begin
            mon_step(tx, tx_done);
         end else begin
            m_active = 1'b0;
            m_stray  = 1'b0;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end else begin
         $display("check %s = %0d ok", name, act);
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      @(negedge clk);
      wr_data  = b;
      wr_valid = 1'b1;
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   task automatic wait_ticks(input int n);
      repeat (2 * n) @(negedge clk);
   endtask

   task automatic wait_busy(input int bound);
      int n = 0;
      @(negedge clk);
      while (tx_busy !== 1'b1 && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (tx_busy !== 1'b1) begin
         total++;
         bad++;
         $display("FAIL wait_busy: tx_busy still %b after %0d cycles, want 1", tx_busy, bound);
      end
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      @(negedge clk);
      while (!(tx_busy === 1'b0 && fifo_empty === 1'b1) && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (tx_busy !== 1'b0) begin
         total++;
         bad++;
         $display("FAIL wait_idle: tx_busy still %b after %0d cycles, want 0", tx_busy, bound);
      end
      repeat (2) @(negedge clk);
   endtask

   vec_t vecs [9];
   int   accepted;
   int   errs;
   int   busy_seen;

   initial begin
      vecs[0] = '{8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8, 1'b0, 6'd16};
      vecs[1] = '{8'h41, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 4'd7, 1'b0, 6'd16};
      vecs[2] = '{8'h41, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7, 1'b1, 6'd16};
      vecs[3] = '{8'h41, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 4'd7, 1'b0, 6'd16};
      vecs[4] = '{8'h1F, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 6'd24};
      vecs[5] = '{8'h1F, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'd8, 1'b0, 6'd32};
      vecs[6] = '{8'h2D, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd6, 1'b1, 6'd32};
      vecs[7] = '{8'hE3, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd5, 1'b0, 6'd16};
      vecs[8] = '{8'h00, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 4'd8, 1'b1, 6'd16};

      // Reset values, sampled while rst_n is held low.
      repeat (4) @(negedge clk);
      chk("rst_tx", int'(tx), 1);
      chk("rst_tx_busy", int'(tx_busy), 0);
      chk("rst_tx_done", int'(tx_done), 0);
      chk("rst_fifo_empty", int'(fifo_empty), 1);
      chk("rst_fifo_full", int'(fifo_full), 0);
      chk("rst_fifo_count", int'(fifo_count), 0);
      chk("rst_wr_ready", int'(wr_ready), 1);
      rst_n    = 1'b1;
      tick_run = 1'b1;
      repeat (4) @(negedge clk);

      // Single frames across formats; line control is scrambled mid-frame.
      for (int v = 0; v < 9; v++) begin
         lcr_wls = vecs[v].wls;
         lcr_stb = vecs[v].stb;
         lcr_pen = vecs[v].pen;
         lcr_eps = vecs[v].eps;
         lcr_sp  = vecs[v].sp;
         exp_q.push_back(mk_frame(vecs[v].b, int'(vecs[v].nd), vecs[v].pen,
                                  vecs[v].par, int'(vecs[v].stop), 1'b0));
         busy_ticks = 0;
         done_cnt   = 0;
         push_byte(vecs[v].b);
         wait_busy(50);
         lcr_wls = ~vecs[v].wls;
         lcr_stb = ~vecs[v].stb;
         lcr_pen = ~vecs[v].pen;
         lcr_eps = ~vecs[v].eps;
         lcr_sp  = ~vecs[v].sp;
         wait_idle(2000);
         chk($sformatf("v%0d_busy_ticks", v), busy_ticks,
             (1 + int'(vecs[v].nd) + int'(vecs[v].pen)) * OS + int'(vecs[v].stop));
         chk($sformatf("v%0d_done_pulses", v), done_cnt, 1);
      end

      // Burst of 17 with ticks halted: 16 fit, then back-to-back 8N1 frames.
      lcr_wls = 2'd3; lcr_stb = 1'b0; lcr_pen = 1'b0; lcr_eps = 1'b0; lcr_sp = 1'b0;
      tick_run = 1'b0;
      repeat (4) @(negedge clk);
      accepted = 0;
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         wr_data  = 8'h30 + 8'(i);
         wr_valid = 1'b1;
         if (wr_ready) accepted++;
      end
      @(negedge clk);
      wr_valid = 1'b0;
      chk("burst_accepted", accepted, 16);
      chk("burst_fifo_full", int'(fifo_full), 1);
      chk("burst_fifo_count", int'(fifo_count), 16);
      chk("burst_wr_ready", int'(wr_ready), 0);
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back(mk_frame(8'h30 + 8'(i), 8, 1'b0, 1'b0, 16, (i != 15)));
      end
      done_cnt = 0;
      tick_run = 1'b1;
      wait_busy(50);
      chk("burst_count_after_pop", int'(fifo_count), 15);
      wait_idle(8000);
      chk("burst_done_pulses", done_cnt, 16);

      // Break for 40 ticks mid-frame; FIFO still drains.
      mon_en   = 1'b0;
      done_cnt = 0;
      push_byte(8'h55);
      push_byte(8'hAA);
      wait_busy(50);
      wait_ticks(30);
      lcr_brk = 1'b1;
      errs = 0;
      for (int i = 0; i < 40; i++) begin
         wait_ticks(1);
         if (tx !== 1'b0) errs++;
      end
      chk("break_tx_high_ticks", errs, 0);
      lcr_brk = 1'b0;
      wait_idle(2000);
      chk("break_fifo_empty", int'(fifo_empty), 1);
      chk("break_tx_idle", int'(tx), 1);
      chk("break_done_pulses", done_cnt, 2);

      // Reset in the middle of DATA.
      push_byte(8'h5A);
      push_byte(8'h3C);
      wait_busy(50);
      wait_ticks(40);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_tx", int'(tx), 1);
      chk("midrst_fifo_empty", int'(fifo_empty), 1);
      chk("midrst_fifo_count", int'(fifo_count), 0);
      chk("midrst_tx_busy", int'(tx_busy), 0);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("midrst_stays_idle", int'(tx_busy), 0);
      mon_en = 1'b1;
      repeat (4) @(negedge clk);

      // Clear during DATA, with a coincident push that must be dropped.
      exp_q.push_back(mk_frame(8'h81, 8, 1'b0, 1'b0, 16, 1'b0));
      done_cnt = 0;
      push_byte(8'h81);
      push_byte(8'h42);
      push_byte(8'h24);
      wait_busy(50);
      wait_ticks(40);
      @(negedge clk);
      fifo_clear = 1'b1;
      wr_valid   = 1'b1;
      wr_data    = 8'h77;
      @(negedge clk);
      fifo_clear = 1'b0;
      wr_valid   = 1'b0;
      chk("clear_fifo_count", int'(fifo_count), 0);
      chk("clear_busy_kept", int'(tx_busy), 1);
      wait_idle(2000);
      busy_seen = 0;
      repeat (600) begin
         @(negedge clk);
         if (tx_busy === 1'b1) busy_seen++;
      end
      chk("clear_no_more_frames", busy_seen, 0);
      chk("clear_done_pulses", done_cnt, 1);

      chk("frames_outstanding", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
